// File: rtl/alu_exec_pkg.sv
// rtl/alu_exec_pkg.sv - shared opcodes, FSM states and defaults for the EX-stage ALU
package alu_exec_pkg;

   localparam int ALU_WIDTH = 32;

   localparam logic [3:0] OP_ADD     = 4'b0000;
   localparam logic [3:0] OP_SUB     = 4'b0001;
   localparam logic [3:0] OP_MULT    = 4'b0010;
   localparam logic [3:0] OP_DIV     = 4'b0011;
   localparam logic [3:0] OP_AND     = 4'b0100;
   localparam logic [3:0] OP_OR      = 4'b0101;
   localparam logic [3:0] OP_NOR     = 4'b0110;
   localparam logic [3:0] OP_XOR     = 4'b0111;
   localparam logic [3:0] OP_BNE     = 4'b1000;
   localparam logic [3:0] OP_BGT     = 4'b1001;
   localparam logic [3:0] OP_BGE     = 4'b1010;
   localparam logic [3:0] OP_BLE     = 4'b1011;
   localparam logic [3:0] OP_INVALID = 4'b1111;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ITER,
      S_FIX,
      S_DONE
   } state_t;

   function automatic logic is_muldiv(input logic [3:0] code);
      return (code == OP_MULT) || (code == OP_DIV);
   endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// rtl/alu_exec_unit_if.sv - request/response bundle between control unit and ALU
interface alu_exec_unit_if
   import alu_exec_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) ();
   logic             start;
   logic [3:0]       ALUctr;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             taken;
   logic             ovf;
   logic             div0;
   logic             illegal;

   modport master (
      output start, ALUctr, A, B,
      input  busy, done, result, hi, lo, taken, ovf, div0, illegal
   );

   modport slave (
      input  start, ALUctr, A, B,
      output busy, done, result, hi, lo, taken, ovf, div0, illegal
   );
endinterface

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - unsigned iterative multiply (shift-add) / divide (restoring)
module muldiv_iter #(
   parameter int WIDTH = 32,
   parameter int CW    = 6
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic               step,
   input  logic               mode,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic [CW-1:0]      count,
   output logic [2*WIDTH-1:0] acc
);
   logic             is_div;
   logic [WIDTH-1:0] operand;
   logic [WIDTH:0]   add_sum;
   logic [WIDTH:0]   rem_shift;
   logic [WIDTH-1:0] rem_sub;
   logic             rem_ge;

   // acc = {partial product, multiplier} for MULT, {remainder, quotient} for DIV
   assign add_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
   assign rem_shift = acc[2*WIDTH-1:WIDTH-1];
   assign rem_ge    = rem_shift >= {1'b0, operand};
   assign rem_sub   = rem_shift[WIDTH-1:0] - operand;

   always_ff @(posedge clk) begin
      if (reset) begin
         acc     <= '0;
         count   <= '0;
         is_div  <= 1'b0;
         operand <= '0;
      end else if (load) begin
         acc     <= {{WIDTH{1'b0}}, a};
         operand <= b;
         is_div  <= mode;
         count   <= '0;
      end else if (step) begin
         count <= count + CW'(1);
         if (is_div) begin
            acc <= rem_ge ? {rem_sub, acc[WIDTH-2:0], 1'b1}
                          : {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
         end else begin
            acc <= acc[0] ? {add_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
         end
      end
   end
endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - EX-stage ALU: single-cycle ops plus iterative signed MULT/DIV
module alu_exec_unit
   import alu_exec_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH,
   parameter int ITER  = WIDTH
) (
   input  logic clk,
   input  logic reset,
   alu_exec_unit_if.slave bus
);
   localparam int CW  = $clog2(ITER + 1);
   localparam int MSB = WIDTH - 1;

   state_t             state;
   logic               is_div, sign_a, sign_b, b_zero;
   logic [WIDTH-1:0]   a_raw;
   logic               md_load, md_step;
   logic [CW-1:0]      md_count;
   logic [2*WIDTH-1:0] md_acc;
   logic [WIDTH-1:0]   a_abs, b_abs, sum, diff;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quo, rem;
   logic [WIDTH-1:0]   sc_result;
   logic               sc_ovf, sc_taken, sc_illegal, sets_ovf, sets_taken;

   assign sum     = bus.A + bus.B;
   assign diff    = bus.A - bus.B;
   assign a_abs   = bus.A[MSB] ? -bus.A : bus.A;
   assign b_abs   = bus.B[MSB] ? -bus.B : bus.B;
   assign md_load = (state == S_IDLE) && bus.start && is_muldiv(bus.ALUctr);
   assign md_step = (state == S_ITER);

   muldiv_iter #(.WIDTH(WIDTH), .CW(CW)) u_muldiv (
      .clk   (clk),
      .reset (reset),
      .load  (md_load),
      .step  (md_step),
      .mode  (bus.ALUctr == OP_DIV),
      .a     (a_abs),
      .b     (b_abs),
      .count (md_count),
      .acc   (md_acc)
   );

   // Remainder follows the dividend's sign; quotient and product follow sign_a^sign_b
   assign prod = (sign_a ^ sign_b) ? -md_acc : md_acc;
   assign quo  = (sign_a ^ sign_b) ? -md_acc[WIDTH-1:0] : md_acc[WIDTH-1:0];
   assign rem  = sign_a ? -md_acc[2*WIDTH-1:WIDTH] : md_acc[2*WIDTH-1:WIDTH];

   always_comb begin
      sc_result  = '0;
      sc_ovf     = 1'b0;
      sc_taken   = 1'b0;
      sc_illegal = 1'b0;
      sets_ovf   = 1'b0;
      sets_taken = 1'b0;
      case (bus.ALUctr)
         OP_ADD: begin
            sc_result = sum;
            sc_ovf    = (bus.A[MSB] == bus.B[MSB]) && (sum[MSB] != bus.A[MSB]);
            sets_ovf  = 1'b1;
         end
         OP_SUB: begin
            sc_result = diff;
            sc_ovf    = (bus.A[MSB] != bus.B[MSB]) && (diff[MSB] != bus.A[MSB]);
            sets_ovf  = 1'b1;
         end
         OP_AND: sc_result = bus.A & bus.B;
         OP_OR:  sc_result = bus.A | bus.B;
         OP_NOR: sc_result = ~(bus.A | bus.B);
         OP_XOR: sc_result = bus.A ^ bus.B;
         OP_BNE, OP_BGT, OP_BGE, OP_BLE: begin
            sc_result  = diff;
            sets_taken = 1'b1;
            case (bus.ALUctr)
               OP_BNE:  sc_taken = bus.A != bus.B;
               OP_BGT:  sc_taken = $signed(bus.A) >  $signed(bus.B);
               OP_BGE:  sc_taken = $signed(bus.A) >= $signed(bus.B);
               default: sc_taken = $signed(bus.A) <= $signed(bus.B);
            endcase
         end
         OP_MULT, OP_DIV: sc_result = '0;
         default: sc_illegal = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         is_div      <= 1'b0;
         sign_a      <= 1'b0;
         sign_b      <= 1'b0;
         b_zero      <= 1'b0;
         a_raw       <= '0;
         bus.busy    <= 1'b0;
         bus.done    <= 1'b0;
         bus.result  <= '0;
         bus.hi      <= '0;
         bus.lo      <= '0;
         bus.taken   <= 1'b0;
         bus.ovf     <= 1'b0;
         bus.div0    <= 1'b0;
         bus.illegal <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start && is_muldiv(bus.ALUctr)) begin
                  is_div   <= (bus.ALUctr == OP_DIV);
                  sign_a   <= bus.A[MSB];
                  sign_b   <= bus.B[MSB];
                  b_zero   <= (bus.B == '0);
                  a_raw    <= bus.A;
                  bus.busy <= 1'b1;
                  state    <= S_ITER;
               end else if (bus.start) begin
                  bus.result  <= sc_result;
                  bus.illegal <= sc_illegal;
                  if (sets_ovf)   bus.ovf   <= sc_ovf;
                  if (sets_taken) bus.taken <= sc_taken;
                  bus.done    <= 1'b1;
                  state       <= S_DONE;
               end
            end
            S_ITER: begin
               if (md_count == CW'(ITER - 1)) state <= S_FIX;
            end
            S_FIX: begin
               if (is_div) begin
                  bus.hi     <= b_zero ? a_raw : rem;
                  bus.lo     <= b_zero ? {WIDTH{1'b1}} : quo;
                  bus.result <= b_zero ? {WIDTH{1'b1}} : quo;
                  bus.div0   <= b_zero;
               end else begin
                  bus.hi     <= prod[2*WIDTH-1:WIDTH];
                  bus.lo     <= prod[WIDTH-1:0];
                  bus.result <= prod[WIDTH-1:0];
               end
               bus.illegal <= 1'b0;
               bus.busy    <= 1'b0;
               bus.done    <= 1'b1;
               state       <= S_DONE;
            end
            S_DONE: begin
               bus.done <= 1'b0;
               state    <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - directed vector bench for alu_exec_unit
module tb_alu_exec_unit;
   import alu_exec_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   tests = 0;
   int   fails = 0;

   alu_exec_unit_if #(.WIDTH(32)) bus ();

   alu_exec_unit #(.WIDTH(32), .ITER(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  code;
      logic [31:0] a;
      logic [31:0] b;
      int          lat;
      logic [31:0] res;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        taken;
      logic        ovf;
      logic        div0;
      logic        ill;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic [31:0] res, input logic [31:0] hi,
                             input logic [31:0] lo, input logic taken, input logic ovf,
                             input logic div0, input logic ill);
      check({tag, ".result"},  64'(bus.result),  64'(res));
      check({tag, ".hi"},      64'(bus.hi),      64'(hi));
      check({tag, ".lo"},      64'(bus.lo),      64'(lo));
      check({tag, ".taken"},   64'(bus.taken),   64'(taken));
      check({tag, ".ovf"},     64'(bus.ovf),     64'(ovf));
      check({tag, ".div0"},    64'(bus.div0),    64'(div0));
      check({tag, ".illegal"}, 64'(bus.illegal), 64'(ill));
   endtask

   task automatic launch(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      bus.start  = 1'b1;
      bus.ALUctr = code;
      bus.A      = a;
      bus.B      = b;
      @(posedge clk);
      #1;
      bus.start  = 1'b0;
      bus.ALUctr = 4'($urandom);
      bus.A      = $urandom;
      bus.B      = $urandom;
   endtask

   task automatic run_op(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int busy_n);
      launch(code, a, b);
      lat    = 0;
      busy_n = 0;
      do begin
         @(negedge clk);
         lat++;
         if (bus.busy) busy_n++;
      end while (!bus.done && lat < 100);
   endtask

   function automatic vec_t mk(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                               input int lat, input logic [31:0] res, input logic [31:0] hi,
                               input logic [31:0] lo, input logic taken, input logic ovf,
                               input logic div0, input logic ill);
      vec_t v;
      v.code = code; v.a = a; v.b = b; v.lat = lat; v.res = res; v.hi = hi; v.lo = lo;
      v.taken = taken; v.ovf = ovf; v.div0 = div0; v.ill = ill;
      return v;
   endfunction

   initial begin
      int lat, busy_n, extra_done;
      string tag;

      // Flags are sticky, so expectations depend on table order
      vecs.push_back(mk(OP_ADD,  32'h7FFFFFFF, 32'h00000001,  1, 32'h80000000, 32'h0,        32'h0,        0, 1, 0, 0));
      vecs.push_back(mk(OP_SUB,  32'h80000000, 32'h00000001,  1, 32'h7FFFFFFF, 32'h0,        32'h0,        0, 1, 0, 0));
      vecs.push_back(mk(OP_ADD,  32'h00000005, 32'h00000003,  1, 32'h00000008, 32'h0,        32'h0,        0, 0, 0, 0));
      vecs.push_back(mk(OP_AND,  32'hF0F0F0F0, 32'hFF00FF00,  1, 32'hF000F000, 32'h0,        32'h0,        0, 0, 0, 0));
      vecs.push_back(mk(OP_OR,   32'hF0F0F0F0, 32'h0F0F0000,  1, 32'hFFFFF0F0, 32'h0,        32'h0,        0, 0, 0, 0));
      vecs.push_back(mk(OP_NOR,  32'h0F0F0F0F, 32'hF0F0F0F0,  1, 32'h00000000, 32'h0,        32'h0,        0, 0, 0, 0));
      vecs.push_back(mk(OP_XOR,  32'hAAAA5555, 32'hFFFF0000,  1, 32'h55555555, 32'h0,        32'h0,        0, 0, 0, 0));
      vecs.push_back(mk(OP_MULT, 32'hFFFFFFFD, 32'h00000007, 34, 32'hFFFFFFEB, 32'hFFFFFFFF, 32'hFFFFFFEB, 0, 0, 0, 0));
      vecs.push_back(mk(OP_DIV,  32'hFFFFFFF9, 32'h00000002, 34, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 0, 0, 0));
      vecs.push_back(mk(OP_DIV,  32'h00000005, 32'h00000000, 34, 32'hFFFFFFFF, 32'h00000005, 32'hFFFFFFFF, 0, 0, 1, 0));
      vecs.push_back(mk(OP_BGT,  32'hFFFFFFFF, 32'h00000001,  1, 32'hFFFFFFFE, 32'h00000005, 32'hFFFFFFFF, 0, 0, 1, 0));
      vecs.push_back(mk(OP_BLE,  32'hFFFFFFFF, 32'h00000001,  1, 32'hFFFFFFFE, 32'h00000005, 32'hFFFFFFFF, 1, 0, 1, 0));
      vecs.push_back(mk(OP_BNE,  32'h00000009, 32'h00000009,  1, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 0, 0, 1, 0));
      vecs.push_back(mk(OP_BGE,  32'h00000003, 32'h00000003,  1, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1, 0, 1, 0));
      vecs.push_back(mk(OP_INVALID, 32'h12345678, 32'h1,      1, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1, 0, 1, 1));
      vecs.push_back(mk(OP_ADD,  32'h00000001, 32'h00000001,  1, 32'h00000002, 32'h00000005, 32'hFFFFFFFF, 1, 0, 1, 0));
      vecs.push_back(mk(4'b1100, 32'h00000003, 32'h00000004,  1, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1, 0, 1, 1));
      vecs.push_back(mk(OP_MULT, 32'h80000000, 32'h80000000, 34, 32'h00000000, 32'h40000000, 32'h00000000, 1, 0, 1, 0));
      vecs.push_back(mk(OP_DIV,  32'h80000000, 32'hFFFFFFFF, 34, 32'h80000000, 32'h00000000, 32'h80000000, 1, 0, 0, 0));
      vecs.push_back(mk(OP_DIV,  32'h00000007, 32'hFFFFFFFE, 34, 32'hFFFFFFFD, 32'h00000001, 32'hFFFFFFFD, 1, 0, 0, 0));
      vecs.push_back(mk(OP_MULT, 32'h12345678, 32'h00000010, 34, 32'h23456780, 32'h00000001, 32'h23456780, 1, 0, 0, 0));
      vecs.push_back(mk(OP_SUB,  32'h00000005, 32'h00000007,  1, 32'hFFFFFFFE, 32'h00000001, 32'h23456780, 1, 0, 0, 0));

      reset      = 1'b1;
      bus.start  = 1'b0;
      bus.ALUctr = 4'b0000;
      bus.A      = '0;
      bus.B      = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset.busy", 64'(bus.busy), 64'd0);
      check("reset.done", 64'(bus.done), 64'd0);
      check_outs("reset", 32'h0, 32'h0, 32'h0, 0, 0, 0, 0);
      reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         tag = $sformatf("vec%0d", i);
         run_op(vecs[i].code, vecs[i].a, vecs[i].b, lat, busy_n);
         check({tag, ".latency"}, 64'(lat), 64'(vecs[i].lat));
         check({tag, ".busy_cycles"}, 64'(busy_n), 64'(vecs[i].lat - 1));
         check_outs(tag, vecs[i].res, vecs[i].hi, vecs[i].lo, vecs[i].taken,
                    vecs[i].ovf, vecs[i].div0, vecs[i].ill);
      end

      // start pulsed mid-MULT must be dropped, not queued
      launch(OP_MULT, 32'hFFFFFFFD, 32'h00000007);
      lat = 0;
      busy_n = 0;
      do begin
         @(negedge clk);
         lat++;
         if (bus.busy) busy_n++;
         if (lat == 10) begin
            bus.start  = 1'b1;
            bus.ALUctr = OP_ADD;
            bus.A      = 32'h1;
            bus.B      = 32'h1;
         end else begin
            bus.start = 1'b0;
         end
      end while (!bus.done && lat < 100);
      bus.start = 1'b0;
      check("ignore.latency", 64'(lat), 64'd34);
      check("ignore.busy_cycles", 64'(busy_n), 64'd33);
      check_outs("ignore", 32'hFFFFFFEB, 32'hFFFFFFFF, 32'hFFFFFFEB, 1, 0, 0, 0);
      extra_done = 0;
      repeat (3) begin
         @(negedge clk);
         if (bus.done) extra_done++;
      end
      check("ignore.no_queued_done", 64'(extra_done), 64'd0);

      // reset in the middle of a DIV aborts it and clears everything
      launch(OP_DIV, 32'h00000064, 32'h00000007);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (lat < 15);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("midreset.busy", 64'(bus.busy), 64'd0);
      check("midreset.done", 64'(bus.done), 64'd0);
      check_outs("midreset", 32'h0, 32'h0, 32'h0, 0, 0, 0, 0);
      extra_done = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done || bus.busy) extra_done++;
      end
      check("midreset.quiet", 64'(extra_done), 64'd0);
      run_op(OP_ADD, 32'h00000010, 32'h00000020, lat, busy_n);
      check("postreset.latency", 64'(lat), 64'd1);
      check_outs("postreset", 32'h00000030, 32'h0, 32'h0, 0, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
